baccarat_dealer: RTL and testbench
==================================

Name: baccarat_dealer

Overview:
Sequential dealing engine for the baccarat datapath. It is the producer side of the card interface that the hand scorer consumes. It deals cards one step at a time into six card registers (player 1-3, dealer 1-3) and applies the standard third-card rules using internally computed hand scores. When the hand is finished it declares the winner.

Parameters:
FACE_MIN, 10, lowest card code scored as 0 (codes FACE_MIN..13 score 0).
NATURAL_MIN, 8, two-card score at or above which the hand ends immediately.

Ports:
slow_clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
step  in  1  advance request; sampled every rising edge.
new_card  in  4  card code offered for the current deal. Valid codes are 1..13.
pcard1, pcard2, pcard3  out  4 each  player card registers.
dcard1, dcard2, dcard3  out  4 each  dealer card registers.
pscore  out  4  player hand score, combinational from the card registers, range 0..9.
dscore  out  4  dealer hand score, same rules as pscore.
busy  out  1  high until the hand is resolved.
done  out  1  high in S_DONE.
player_win  out  1  registered win flag.
dealer_win  out  1  registered win flag.

Behaviour:
- Reset: all card registers = 0, flags = 0, busy = 1, state = S_P1. Reset overrides step in the same cycle and may be asserted in any state.
- Card value: codes 1..9 score their own value. Codes 0 and FACE_MIN..15 score 0. Score = (v1+v2+v3) mod 10; an empty card register contributes 0.
- Deal states: S_P1 -> S_D1 -> S_P2 -> S_D2.
  - A deal state fires only on an edge where step=1 and new_card is in 1..13.
  - On fire: load new_card into that state's register and advance.
  - Otherwise: hold, with no register change (stall). Codes 0, 14 and 15 never load.
- S_EVAL: entered after S_D2, resolved on the next edge without needing step.
  - pscore >= NATURAL_MIN or dscore >= NATURAL_MIN -> S_DONE.
  - Else pscore <= 5 -> S_P3.
  - Else (player stands on 6/7): dscore <= 5 -> S_D3, otherwise S_DONE.
- S_P3: deal state loading pcard3, then -> S_BCHK.
- S_BCHK: resolved on the next edge without needing step. Let t = card value of pcard3 (0..9) and d = dscore.
  - d = 7: stand -> S_DONE.
  - d = 6: draw if t in {6,7}.
  - d = 5: draw if t in 4..7.
  - d = 4: draw if t in 2..7.
  - d = 3: draw unless t = 8.
  - d <= 2: draw.
  - Draw -> S_D3, stand -> S_DONE.
- S_D3: deal state loading dcard3, then -> S_DONE.
- S_DONE:
  - On the entering edge, player_win <= (pscore > dscore) or tie, and dealer_win <= (dscore > pscore) or tie. A tie sets both flags.
  - busy = 0, done = 1.
  - Holds until reset; step is ignored.
- Latency:
  - A loaded card is visible on outputs, and in pscore/dscore, the cycle after its firing edge.
  - The hand resolves at minimum 5 edges after reset release (natural) and at maximum 8 fire/eval edges.

Test Plan:
1. Natural: deal P1=4, D1=2, P2=5, D2=3 -> p=9, d=5. Next edge gives done=1, player_win=1, dealer_win=0, pcard3=dcard3=0.
2. Banker 3 stands on 8: deal 1,1,2,2 -> p=3, d=3. P3=8 -> p=1. S_BCHK stands; done with dealer_win=1, player_win=0, dcard3=0.
3. Player stands, banker draws: deal 13,2,7,3 -> p=7, d=5. Only D3 is dealt: D3=1 -> d=6. Result player_win=1, pcard3=0.
4. Tie: deal 10,11,12,13 -> p=d=0. P3=5 -> p=5; banker at 0 draws. D3=5 -> d=5. Both flags=1.
5. Stall: in S_P1, step=1 with new_card=0 then 14 -> no change. Then step=0 with new_card=6 -> no change. Then step=1 with new_card=6 -> pcard1=6.
6. Reset mid-hand: assert reset in S_BCHK -> all cards and flags 0, busy=1, state S_P1. The next valid deal loads pcard1.

Source files
------------

// File: rtl/baccarat_dealer.sv
`default_nettype none
// ============================================================================
//  Module   : baccarat_dealer
//  Purpose  : Sequential baccarat dealing engine. Deals one card per accepted
//             step into six card registers, applies the third-card rules from
//             internally computed hand scores and declares the winner.
//  Ports    : slow_clock            - clock, rising-edge active
//             reset                 - synchronous, active-high
//             step                  - advance request for deal states
//             new_card[3:0]         - card code offered (valid 1..13)
//             pcard1..3 / dcard1..3 - player / dealer card registers
//             pscore / dscore       - combinational hand scores (0..9)
//             busy / done           - hand in progress / hand resolved
//             player_win/dealer_win - registered result flags (tie sets both)
//  Revision : 1.0 - initial release
// ============================================================================
module baccarat_dealer #(
  parameter int FACE_MIN    = 10,
  parameter int NATURAL_MIN = 8
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] new_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       busy,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win
);

  typedef enum logic [3:0] {
    S_P1   = 4'd0,
    S_D1   = 4'd1,
    S_P2   = 4'd2,
    S_D2   = 4'd3,
    S_EVAL = 4'd4,
    S_P3   = 4'd5,
    S_BCHK = 4'd6,
    S_D3   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  // Pip value of a card code: 1..9 count face value, empty/tens/faces count 0.
  function automatic logic [3:0] card_val(input logic [3:0] c);
    if (c >= 4'd1 && c <= 4'd9 && int'(c) < FACE_MIN) return c;
    else return 4'd0;
  endfunction

  // Hand score is the last digit of the pip sum; max sum is 27.
  function automatic logic [3:0] hand_score(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] s;
    s = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
    if (s >= 5'd20)      s = s - 5'd20;
    else if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  state_t     r_state, w_next;
  logic [3:0] r_pcard1, r_pcard2, r_pcard3, r_dcard1, r_dcard2, r_dcard3;
  logic       r_player_win, r_dealer_win;
  logic       w_fire;
  logic       w_ld_p1, w_ld_d1, w_ld_p2, w_ld_d2, w_ld_p3, w_ld_d3;
  logic       w_draw;
  logic [3:0] w_t;
  logic [3:0] w_pscore_fin, w_dscore_fin;
  logic       w_enter_done;

  assign w_fire = step && (new_card >= 4'd1) && (new_card <= 4'd13);
  assign w_t    = card_val(r_pcard3);

  assign pscore = hand_score(r_pcard1, r_pcard2, r_pcard3);
  assign dscore = hand_score(r_dcard1, r_dcard2, r_dcard3);

  // The result is judged on the hand as it stands after this edge, so a
  // third card loaded on the entering edge is already counted.
  assign w_pscore_fin = hand_score(r_pcard1, r_pcard2, w_ld_p3 ? new_card : r_pcard3);
  assign w_dscore_fin = hand_score(r_dcard1, r_dcard2, w_ld_d3 ? new_card : r_dcard3);
  assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);

  // Banker third-card table, indexed by banker score and player's third pip.
  always_comb begin
    w_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: w_draw = 1'b1;
      4'd3:             w_draw = (w_t != 4'd8);
      4'd4:             w_draw = (w_t >= 4'd2) && (w_t <= 4'd7);
      4'd5:             w_draw = (w_t >= 4'd4) && (w_t <= 4'd7);
      4'd6:             w_draw = (w_t == 4'd6) || (w_t == 4'd7);
      default:          w_draw = 1'b0;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_ld_p1 = 1'b0;
    w_ld_d1 = 1'b0;
    w_ld_p2 = 1'b0;
    w_ld_d2 = 1'b0;
    w_ld_p3 = 1'b0;
    w_ld_d3 = 1'b0;
    case (r_state)
      S_P1: if (w_fire) begin w_ld_p1 = 1'b1; w_next = S_D1; end
      S_D1: if (w_fire) begin w_ld_d1 = 1'b1; w_next = S_P2; end
      S_P2: if (w_fire) begin w_ld_p2 = 1'b1; w_next = S_D2; end
      S_D2: if (w_fire) begin w_ld_d2 = 1'b1; w_next = S_EVAL; end
      S_EVAL: begin
        if (int'(pscore) >= NATURAL_MIN || int'(dscore) >= NATURAL_MIN)
          w_next = S_DONE;
        else if (pscore <= 4'd5)
          w_next = S_P3;
        else if (dscore <= 4'd5)
          w_next = S_D3;
        else
          w_next = S_DONE;
      end
      S_P3: if (w_fire) begin w_ld_p3 = 1'b1; w_next = S_BCHK; end
      S_BCHK: w_next = w_draw ? S_D3 : S_DONE;
      S_D3: if (w_fire) begin w_ld_d3 = 1'b1; w_next = S_DONE; end
      S_DONE: w_next = S_DONE;
      default: w_next = S_P1;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_state      <= S_P1;
      r_pcard1     <= 4'd0;
      r_pcard2     <= 4'd0;
      r_pcard3     <= 4'd0;
      r_dcard1     <= 4'd0;
      r_dcard2     <= 4'd0;
      r_dcard3     <= 4'd0;
      r_player_win <= 1'b0;
      r_dealer_win <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ld_p1) r_pcard1 <= new_card;
      if (w_ld_d1) r_dcard1 <= new_card;
      if (w_ld_p2) r_pcard2 <= new_card;
      if (w_ld_d2) r_dcard2 <= new_card;
      if (w_ld_p3) r_pcard3 <= new_card;
      if (w_ld_d3) r_dcard3 <= new_card;
      if (w_enter_done) begin
        r_player_win <= (w_pscore_fin >= w_dscore_fin);
        r_dealer_win <= (w_dscore_fin >= w_pscore_fin);
      end
    end
  end

  assign pcard1     = r_pcard1;
  assign pcard2     = r_pcard2;
  assign pcard3     = r_pcard3;
  assign dcard1     = r_dcard1;
  assign dcard2     = r_dcard2;
  assign dcard3     = r_dcard3;
  assign busy       = (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign player_win = r_player_win;
  assign dealer_win = r_dealer_win;

endmodule
`default_nettype wire

// File: tb/tb_baccarat_dealer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_baccarat_dealer
//  Purpose  : Directed self-checking bench for baccarat_dealer. Each task
//             plays one scenario with hand-computed expected results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_baccarat_dealer;

  logic       slow_clock = 1'b0;
  logic       reset      = 1'b1;
  logic       step       = 1'b0;
  logic [3:0] new_card   = 4'd0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       busy, done, player_win, dealer_win;

  int passed = 0;
  int total  = 0;

  baccarat_dealer #(.FACE_MIN(10), .NATURAL_MIN(8)) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .step       (step),
    .new_card   (new_card),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .busy       (busy),
    .done       (done),
    .player_win (player_win),
    .dealer_win (dealer_win)
  );

  always #5 slow_clock = ~slow_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // One rising edge with the given inputs; returns sampled #1 after the edge.
  task automatic edge_with(input logic s, input logic [3:0] c);
    @(negedge slow_clock);
    step     = s;
    new_card = c;
    @(posedge slow_clock);
    #1;
    step = 1'b0;
  endtask

  task automatic deal(input logic [3:0] c);
    edge_with(1'b1, c);
  endtask

  task automatic tick();
    edge_with(1'b0, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge slow_clock);
    reset = 1'b1;
    step  = 1'b0;
    @(posedge slow_clock);
    @(negedge slow_clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} !== 24'h0)
      $display("FAIL reset_cards: got %h expected 000000",
               {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3});
    else passed++;
    total++;
    if ({busy, done, player_win, dealer_win} !== 4'b1000)
      $display("FAIL reset_flags: got %b expected 1000",
               {busy, done, player_win, dealer_win});
    else passed++;
  endtask

  task automatic test_natural();
    do_reset();
    deal(4); deal(2); deal(5); deal(3);
    total++;
    if ({pscore, dscore, done} !== {4'd9, 4'd5, 1'b0})
      $display("FAIL natural_scores: got p=%0d d=%0d done=%0b expected p=9 d=5 done=0",
               pscore, dscore, done);
    else passed++;
    tick();
    total++;
    if ({done, busy, player_win, dealer_win} !== 4'b1010)
      $display("FAIL natural_result: got done/busy/pw/dw=%b expected 1010",
               {done, busy, player_win, dealer_win});
    else passed++;
    deal(7);
    total++;
    if ({pcard3, dcard3, done} !== {4'd0, 4'd0, 1'b1})
      $display("FAIL natural_third_cards: got p3=%0d d3=%0d done=%0b expected 0 0 1",
               pcard3, dcard3, done);
    else passed++;
  endtask

  task automatic test_banker3_stands_on_8();
    do_reset();
    deal(1); deal(1); deal(2); deal(2);
    total++;
    if ({pscore, dscore} !== {4'd3, 4'd3})
      $display("FAIL b3_scores: got p=%0d d=%0d expected p=3 d=3", pscore, dscore);
    else passed++;
    tick();
    deal(8);
    total++;
    if ({pcard3, pscore, done} !== {4'd8, 4'd1, 1'b0})
      $display("FAIL b3_p3: got p3=%0d p=%0d done=%0b expected 8 1 0",
               pcard3, pscore, done);
    else passed++;
    tick();
    total++;
    if ({done, player_win, dealer_win, dcard3} !== {3'b101, 4'd0})
      $display("FAIL b3_result: got done=%0b pw=%0b dw=%0b d3=%0d expected 1 0 1 0",
               done, player_win, dealer_win, dcard3);
    else passed++;
  endtask

  task automatic test_player_stands();
    do_reset();
    deal(13); deal(2); deal(7); deal(3);
    total++;
    if ({pscore, dscore} !== {4'd7, 4'd5})
      $display("FAIL ps_scores: got p=%0d d=%0d expected p=7 d=5", pscore, dscore);
    else passed++;
    tick();
    deal(1);
    total++;
    if ({done, dcard3, dscore, pcard3, player_win, dealer_win} !==
        {1'b1, 4'd1, 4'd6, 4'd0, 2'b10})
      $display("FAIL ps_result: got done=%0b d3=%0d d=%0d p3=%0d pw=%0b dw=%0b expected 1 1 6 0 1 0",
               done, dcard3, dscore, pcard3, player_win, dealer_win);
    else passed++;
  endtask

  task automatic test_tie();
    do_reset();
    deal(10); deal(11); deal(12); deal(13);
    total++;
    if ({pscore, dscore} !== 8'h00)
      $display("FAIL tie_scores: got p=%0d d=%0d expected 0 0", pscore, dscore);
    else passed++;
    tick();
    deal(5);
    tick();
    total++;
    if ({busy, pscore, dcard3} !== {1'b1, 4'd5, 4'd0})
      $display("FAIL tie_banker_draws: got busy=%0b p=%0d d3=%0d expected 1 5 0",
               busy, pscore, dcard3);
    else passed++;
    deal(5);
    total++;
    if ({done, dscore, player_win, dealer_win} !== {1'b1, 4'd5, 2'b11})
      $display("FAIL tie_result: got done=%0b d=%0d pw=%0b dw=%0b expected 1 5 1 1",
               done, dscore, player_win, dealer_win);
    else passed++;
  endtask

  // Banker on 6 draws when the player's third card is a 6.
  task automatic test_banker6_draws();
    do_reset();
    deal(1); deal(3); deal(2); deal(3);
    tick();
    deal(6);
    tick();
    total++;
    if ({busy, pscore, dscore} !== {1'b1, 4'd9, 4'd6})
      $display("FAIL b6_draw_state: got busy=%0b p=%0d d=%0d expected 1 9 6",
               busy, pscore, dscore);
    else passed++;
    deal(4);
    total++;
    if ({done, dcard3, dscore, player_win, dealer_win} !== {1'b1, 4'd4, 4'd0, 2'b10})
      $display("FAIL b6_result: got done=%0b d3=%0d d=%0d pw=%0b dw=%0b expected 1 4 0 1 0",
               done, dcard3, dscore, player_win, dealer_win);
    else passed++;
  endtask

  task automatic test_stall();
    logic [3:0] bad [3];
    bad[0] = 4'd0; bad[1] = 4'd14; bad[2] = 4'd15;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      deal(bad[i]);
      total++;
      if ({pcard1, dcard1} !== 8'h00)
        $display("FAIL stall_code_%0d: got p1=%0d d1=%0d expected 0 0",
                 bad[i], pcard1, dcard1);
      else passed++;
    end
    edge_with(1'b0, 4'd6);
    total++;
    if (pcard1 !== 4'd0)
      $display("FAIL stall_no_step: got p1=%0d expected 0", pcard1);
    else passed++;
    deal(6);
    total++;
    if ({pcard1, dcard1} !== {4'd6, 4'd0})
      $display("FAIL stall_release: got p1=%0d d1=%0d expected 6 0", pcard1, dcard1);
    else passed++;
    deal(9);
    total++;
    if ({pcard1, dcard1, dscore} !== {4'd6, 4'd9, 4'd9})
      $display("FAIL stall_next_deal: got p1=%0d d1=%0d d=%0d expected 6 9 9",
               pcard1, dcard1, dscore);
    else passed++;
  endtask

  task automatic test_reset_mid_hand();
    do_reset();
    deal(1); deal(1); deal(2); deal(2);
    tick();
    deal(8);
    // Now in the banker-check state; reset overrides the pending resolve.
    @(negedge slow_clock);
    reset = 1'b1;
    step  = 1'b1;
    new_card = 4'd3;
    @(posedge slow_clock);
    #1;
    total++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} !== 24'h0 ||
        {busy, done, player_win, dealer_win} !== 4'b1000)
      $display("FAIL midreset_clear: got cards=%h flags=%b expected 000000 1000",
               {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3},
               {busy, done, player_win, dealer_win});
    else passed++;
    @(negedge slow_clock);
    reset = 1'b0;
    step  = 1'b0;
    deal(3);
    total++;
    if ({pcard1, dcard1, pscore} !== {4'd3, 4'd0, 4'd3})
      $display("FAIL midreset_redeal: got p1=%0d d1=%0d p=%0d expected 3 0 3",
               pcard1, dcard1, pscore);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_natural();
    test_banker3_stands_on_8();
    test_player_stands();
    test_tie();
    test_banker6_draws();
    test_stall();
    test_reset_mid_hand();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
